huff_count_ctrl: RTL and testbench
==================================

Name: huff_count_ctrl

Overview:
- Job sequencer for the symbol-frequency counter stage of the Huffman encoder.
- Buffers one job of BCD nibbles from an upstream valid/ready stream, clears and arms the counter, then streams the job gap-free, one nibble per cycle (the counter cannot stall).
- Collects completion, then hands off to the tree builder through a req/ack handshake.

Parameters:
- DEPTH, 256, maximum digit symbols per job; must equal counter capacity.
- AW, 8, log2(DEPTH); buffer address width.
- TIMEOUT, 8, cycles allowed in WAIT_FIN for Cnt_fin before Err.

Ports:
- Clk_in  in  1  single clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- Job_start  in  1  one-cycle pulse; starts a job when idle.
- Sym_valid  in  1  upstream symbol valid.
- Sym_data  in  4  upstream symbol; 0-9 digit, 4'hA-4'hF terminator.
- Sym_ready  out  1  symbol accepted when Sym_valid & Sym_ready.
- Cnt_nrst  out  1  active-low clear to the counter.
- Cnt_start  out  1  counter arm pulse.
- Cnt_data  out  4  nibble stream to the counter.
- Cnt_fin  in  1  counter full-capacity finish flag.
- Tree_req  out  1  counts valid; request to tree builder.
- Tree_ack  in  1  tree builder accepted.
- Sym_count  out  9  digits in the current job, 0..256.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on successful handoff.
- Err  out  1  sticky timeout error; cleared by next accepted Job_start.

Behaviour:
- Reset values, asynchronous on nRst low, from any state:
  - State IDLE.
  - Sym_ready=0, Cnt_nrst=1, Cnt_start=0, Cnt_data=4'hF, Tree_req=0.
  - Sym_count=0, Busy=0, Done=0, Err=0.
  - Write and read pointers 0; buffer contents undefined.
- IDLE:
  - Job_start=1 -> LOAD; clears Sym_count, pointers and Err.
  - Job_start in any other state is ignored.
- LOAD:
  - Sym_ready=1.
  - Each accepted digit is written to buf[wp]; wp and Sym_count increment.
  - An accepted terminator is not stored -> CLEAR.
  - The 256th accepted digit -> CLEAR; Sym_ready drops the next cycle.
  - A terminator as the first symbol gives an empty job (Sym_count=0), which still runs.
- CLEAR: Cnt_nrst=0 for exactly 1 cycle -> ARM.
- ARM: Cnt_start=1 for exactly 1 cycle -> BURST, with rp=0.
- BURST: one nibble per cycle, no gaps.
  - Cycle k (k < Sym_count) drives Cnt_data=buf[k].
  - If Sym_count<256: cycle Sym_count drives 4'hF -> HANDOFF.
  - If Sym_count=256: after cycle 255 -> WAIT_FIN.
  - Buffer read is registered and prefetched during ARM, so there are no bubbles.
- WAIT_FIN:
  - Cnt_data=4'hF.
  - Cnt_fin=1 -> HANDOFF.
  - TIMEOUT cycles without Cnt_fin -> Err=1, go to IDLE, no Done.
- HANDOFF:
  - Tree_req=1 and held until Tree_ack=1.
  - Tree_ack while Tree_req=0 is ignored.
  - Tree_ack in the same cycle Tree_req rises is valid, giving a 1-cycle handshake.
  - On ack: Done=1 for 1 cycle, Tree_req drops, go to IDLE.
  - Sym_count holds until the next Job_start.
- Cnt_data is 4'hF in every state other than BURST.
- Latency: Job_start to first Cnt_data = 1 + LOAD cycles + 2.
- Counters are 9 bits wide and cannot wrap; wp is AW bits, and the wrap from 255 to 0 coincides with leaving LOAD.

Optional Feature:
- HUFF_CTRL_TIMEOUT_EN.
- Defined: WAIT_FIN watchdog active as above; Err reachable.
- Undefined: no watchdog counter; WAIT_FIN waits indefinitely for Cnt_fin; Err tied to 0.

Decomposition:
- Shared package holds:
  - state enum: IDLE, LOAD, CLEAR, ARM, BURST, WAIT_FIN, HANDOFF;
  - SYM_TERM=4'hF;
  - SYM_DIGIT_MAX=4'h9;
  - DEPTH and AW defaults.
- One sub-module, huff_sym_buf: DEPTH x 4 simple dual-port RAM with a registered read port.

Test Plan:
1. Job of digits 3,3,7 then 4'hA -> Sym_count=3; Cnt_nrst low 1 cycle; Cnt_start 1 cycle; Cnt_data 3,3,7,F on consecutive cycles; Tree_req high; ack -> Done pulse.
2. 256 digits (i mod 10), no terminator -> Sym_ready drops after the 256th; 256 gap-free nibbles; WAIT_FIN; Cnt_fin -> handoff; Sym_count=256.
3. Sym_valid toggling every other cycle during LOAD -> BURST output still gap-free and in order.
4. Cnt_fin withheld with HUFF_CTRL_TIMEOUT_EN defined -> Err=1 after 8 cycles, IDLE, no Done. Next Job_start clears Err.
5. nRst pulsed low mid-BURST -> all outputs at reset values immediately; Job_start then runs a clean job.
6. Terminator as the first symbol -> Sym_count=0; single 4'hF in BURST; handoff completes; Job_start during HANDOFF ignored.

Source files
------------

// File: rtl/huff_count_ctrl_pkg.sv
// Shared types and constants for the Huffman symbol-count job sequencer.
package huff_count_ctrl_pkg;
  localparam int DEPTH_DEF   = 256;
  localparam int AW_DEF      = 8;
  localparam int TIMEOUT_DEF = 8;

  localparam logic [3:0] SYM_TERM      = 4'hF;
  localparam logic [3:0] SYM_DIGIT_MAX = 4'h9;

  typedef enum logic [2:0] {
    IDLE, LOAD, CLEAR, ARM, BURST, WAIT_FIN, HANDOFF
  } state_e;

  function automatic logic is_digit(input logic [3:0] s);
    return s <= SYM_DIGIT_MAX;
  endfunction
endpackage

// File: rtl/huff_count_ctrl_sym_buf.sv
// DEPTH x 4 simple dual-port job buffer; the read port is registered (1-cycle latency).
module huff_sym_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [3:0]    rdata_o
);
  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/huff_count_ctrl.sv
// Job sequencer for the symbol-frequency counter: buffer, clear/arm, gap-free burst, handoff.
// Optional WAIT_FIN watchdog enabled by defining HUFF_CTRL_TIMEOUT_EN.
module huff_count_ctrl
  import huff_count_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = AW_DEF
`ifdef HUFF_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic        Clk_in,
  input  logic        nRst,
  input  logic        Job_start,
  input  logic        Sym_valid,
  input  logic [3:0]  Sym_data,
  output logic        Sym_ready,
  output logic        Cnt_nrst,
  output logic        Cnt_start,
  output logic [3:0]  Cnt_data,
  input  logic        Cnt_fin,
  output logic        Tree_req,
  input  logic        Tree_ack,
  output logic [AW:0] Sym_count,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   rp_q, rp_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          we;
  logic [AW-1:0] raddr;
  logic [3:0]    rdata;
  logic          wd_expire;

`ifdef HUFF_CTRL_TIMEOUT_EN
  localparam int            WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_q, wd_d;

  // Counts WAIT_FIN cycles; parked at zero everywhere else.
  always_comb wd_d = (state_q == WAIT_FIN) ? wd_q + 1'b1 : '0;

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign wd_expire = (wd_q == WD_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    rp_d    = rp_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: if (Job_start) begin
        state_d = LOAD;
        wp_d    = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      LOAD: if (Sym_valid) begin
        if (is_digit(Sym_data)) begin
          we    = 1'b1;
          wp_d  = wp_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = CLEAR;
        end else begin
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = ARM;
      ARM: begin
        state_d = BURST;
        rp_d    = '0;
      end
      BURST: begin
        rp_d = rp_q + 1'b1;
        // A full job has no terminator slot; the counter reports fin instead.
        if (cnt_q == CNT_FULL && rp_q == CNT_LAST) state_d = WAIT_FIN;
        else if (rp_q == cnt_q)                    state_d = HANDOFF;
      end
      WAIT_FIN: begin
        if (Cnt_fin) state_d = HANDOFF;
        else if (wd_expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      HANDOFF: if (Tree_ack) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      cnt_q   <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Prefetch: address 0 during ARM, then always one ahead of the burst index.
  assign raddr = (state_q == ARM) ? '0 : rp_q[AW-1:0] + 1'b1;

  huff_sym_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk_i   (Clk_in),
    .we_i    (we),
    .waddr_i (wp_q),
    .wdata_i (Sym_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign Sym_ready = (state_q == LOAD);
  assign Cnt_nrst  = (state_q != CLEAR);
  assign Cnt_start = (state_q == ARM);
  assign Cnt_data  = (state_q == BURST && rp_q < cnt_q) ? rdata : SYM_TERM;
  assign Tree_req  = (state_q == HANDOFF);
  assign Sym_count = cnt_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign Err       = err_q;
endmodule

// File: tb/tb_huff_count_ctrl.sv
// Scoreboard bench for huff_count_ctrl: directed jobs push expected nibbles/counts, a monitor checks them.
module tb_huff_count_ctrl;
  logic       Clk_in = 1'b0, nRst = 1'b0, Job_start = 1'b0, Sym_valid = 1'b0;
  logic [3:0] Sym_data = 4'h0;
  logic       Cnt_fin = 1'b0, Tree_ack = 1'b0;
  logic       Sym_ready, Cnt_nrst, Cnt_start, Tree_req, Busy, Done, Err;
  logic [3:0] Cnt_data;
  logic [8:0] Sym_count;

  huff_count_ctrl dut (
    .Clk_in(Clk_in), .nRst(nRst), .Job_start(Job_start), .Sym_valid(Sym_valid),
    .Sym_data(Sym_data), .Sym_ready(Sym_ready), .Cnt_nrst(Cnt_nrst), .Cnt_start(Cnt_start),
    .Cnt_data(Cnt_data), .Cnt_fin(Cnt_fin), .Tree_req(Tree_req), .Tree_ack(Tree_ack),
    .Sym_count(Sym_count), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk_in = ~Clk_in;

  int checks = 0, failures = 0;
  logic [3:0] exp_nib[$];
  int exp_len[$];
  int exp_cnt[$];
  int cur_len = 0;
  int rem = 0, burst_cnt = 0, done_cnt = 0;
  logic prev_nrst = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing or unexpected (got wrong, required correct)", name);
  endtask

  // Monitor: burst nibbles after each Cnt_start, Sym_count at each Done pulse.
  always @(negedge Clk_in) begin
    if (!nRst) begin
      rem = 0;
      prev_nrst = 1'b1;
    end else begin
      if (rem > 0) begin
        if (exp_nib.size() == 0) flag("nibble_underflow");
        else chk("cnt_data", Cnt_data, exp_nib.pop_front());
        rem--;
        if (rem == 0) burst_cnt++;
      end else begin
        chk("cnt_data_idle", Cnt_data, 15);
      end
      if (Cnt_start) begin
        chk("clear_before_arm", prev_nrst, 0);
        if (exp_len.size() == 0) flag("unexpected_arm");
        else rem = exp_len.pop_front();
      end
      if (Done) begin
        chk("req_drop_at_done", Tree_req, 0);
        if (exp_cnt.size() == 0) flag("unexpected_done");
        else chk("sym_count", Sym_count, exp_cnt.pop_front());
        done_cnt++;
      end
      prev_nrst = Cnt_nrst;
    end
  end

  task automatic tick();
    @(posedge Clk_in); #1;
  endtask

  task automatic start_job();
    Job_start = 1'b1; tick(); Job_start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    logic r;
    bit got;
    got = 1'b0;
    Sym_valid = 1'b1; Sym_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk_in); r = Sym_ready; tick(); got = r;
    end
    Sym_valid = 1'b0;
    if (!got) flag("sym_accept_timeout");
  endtask

  task automatic digit(input logic [3:0] d);
    exp_nib.push_back(d); cur_len++; send(d);
  endtask

  task automatic term(input logic [3:0] t);
    exp_nib.push_back(4'hF); exp_len.push_back(cur_len + 1); exp_cnt.push_back(cur_len);
    cur_len = 0; send(t);
  endtask

  task automatic full_job();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin exp_len.push_back(256); exp_cnt.push_back(256); end
      digit(4'(i % 10));
    end
    cur_len = 0;
    @(negedge Clk_in); chk("ready_drop_full", Sym_ready, 0);
  endtask

  task automatic wait_burst(input int prev);
    bit ok = 1'b0;
    for (int i = 0; i < 700 && !ok; i++) begin @(negedge Clk_in); #1; ok = (burst_cnt != prev); end
    if (!ok) flag("burst_timeout");
  endtask

  task automatic wait_done(input int prev);
    bit ok = 1'b0;
    for (int i = 0; i < 700 && !ok; i++) begin @(negedge Clk_in); #1; ok = (done_cnt != prev); end
    if (!ok) flag("done_timeout");
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 700 && !ok; i++) begin @(negedge Clk_in); ok = Tree_req; end
    if (!ok) flag("req_timeout");
  endtask

  task automatic do_handoff(input int delay);
    int d0;
    wait_req();
    repeat (delay) begin @(negedge Clk_in); chk("req_held", Tree_req, 1); end
    Tree_ack = 1'b1; @(posedge Clk_in); #1; Tree_ack = 1'b0;
    d0 = done_cnt;
    wait_done(d0);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_sym_ready"}, Sym_ready, 0);
    chk({tag, "_cnt_nrst"},  Cnt_nrst, 1);
    chk({tag, "_cnt_start"}, Cnt_start, 0);
    chk({tag, "_cnt_data"},  Cnt_data, 15);
    chk({tag, "_tree_req"},  Tree_req, 0);
    chk({tag, "_sym_count"}, Sym_count, 0);
    chk({tag, "_busy"},      Busy, 0);
    chk({tag, "_done"},      Done, 0);
    chk({tag, "_err"},       Err, 0);
  endtask

  initial begin
    int b0, d0;
    #12 reset_check("rst");
    @(negedge Clk_in); nRst = 1'b1;
    tick();

    // 1: short job, stray ack in IDLE ignored, delayed ack
    Tree_ack = 1'b1; tick(); Tree_ack = 1'b0; tick();
    start_job();
    digit(4'd3); digit(4'd3); digit(4'd7); term(4'hA);
    do_handoff(2);

    // 2: full 256-digit job with Cnt_fin
    start_job();
    b0 = burst_cnt;
    full_job();
    wait_burst(b0);
    repeat (2) @(negedge Clk_in);
    chk("wait_fin_busy", Busy, 1);
    Cnt_fin = 1'b1; @(posedge Clk_in); #1; Cnt_fin = 1'b0;
    do_handoff(1);

    // 3: bubbly input, ack held high for a 1-cycle handshake
    Tree_ack = 1'b1; tick(); tick();
    d0 = done_cnt;
    start_job();
    digit(4'd9); tick(); digit(4'd0); tick(); digit(4'd5); tick();
    digit(4'd2); tick(); digit(4'd8); tick(); term(4'hB);
    wait_done(d0);
    Tree_ack = 1'b0;
    chk("idle_after_fast_ack", Busy, 0);

    // 4: Cnt_fin withheld
    start_job();
    b0 = burst_cnt;
    full_job();
    wait_burst(b0);
    repeat (8) @(negedge Clk_in);
    chk("wd_busy_last", Busy, 1);
    chk("wd_err_last", Err, 0);
    @(negedge Clk_in);
`ifdef HUFF_CTRL_TIMEOUT_EN
    chk("timeout_idle", Busy, 0);
    chk("timeout_err", Err, 1);
    void'(exp_cnt.pop_front());
    repeat (3) @(negedge Clk_in);
    chk("err_sticky", Err, 1);
    #1 start_job();
    @(negedge Clk_in); chk("err_cleared", Err, 0);
    tick();
    term(4'hD);
    do_handoff(0);
`else
    chk("no_wd_busy", Busy, 1);
    chk("no_wd_err", Err, 0);
    repeat (20) @(negedge Clk_in);
    chk("no_wd_still_busy", Busy, 1);
    #1 Cnt_fin = 1'b1; @(posedge Clk_in); #1; Cnt_fin = 1'b0;
    do_handoff(0);
`endif

    // 5: reset mid-burst, then a clean job
    start_job();
    for (int i = 0; i < 10; i++) digit(4'(i));
    term(4'hF);
    repeat (5) tick();
    nRst = 1'b0;
    exp_nib.delete(); exp_len.delete(); exp_cnt.delete(); cur_len = 0;
    #1 reset_check("midrst");
    @(negedge Clk_in); @(posedge Clk_in); #2; nRst = 1'b1;
    tick();
    start_job();
    digit(4'd1); digit(4'd2); term(4'hE);
    do_handoff(0);

    // 6: empty job, Job_start during HANDOFF ignored
    start_job();
    term(4'hC);
    wait_req();
    Job_start = 1'b1; @(posedge Clk_in); #1; Job_start = 1'b0;
    @(negedge Clk_in);
    chk("handoff_req_hold", Tree_req, 1);
    chk("handoff_busy", Busy, 1);
    Tree_ack = 1'b1; @(posedge Clk_in); #1; Tree_ack = 1'b0;
    d0 = done_cnt;
    wait_done(d0);
    chk("idle_after_empty", Busy, 0);
    @(negedge Clk_in);
    chk("count_hold", Sym_count, 0);
    chk("job_start_ignored", Busy, 0);

    repeat (3) tick();
    chk("queues_empty", exp_nib.size() + exp_len.size() + exp_cnt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
